// File: rtl/ehgu_basic_pkg.sv
// Shared arithmetic helpers used across EHGU blocks.
package ehgu_basic_pkg;

    // Next value of a counter that runs 0..modulo-1 and wraps to 0.
    function automatic logic [31:0] increment_modulo_unsigned(input logic [31:0] value,
                                                              input logic [31:0] modulo);
        logic [31:0] nxt;
        nxt = value + 32'd1;
        if (nxt >= modulo) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ehgu_clkdiv_pkg.sv
// Types, constants and ratio legality check for the programmable clock divider.
package ehgu_clkdiv_pkg;

    localparam int CLKDIV_MAX_DIV = 256;
    localparam int CLKDIV_DW      = $clog2(CLKDIV_MAX_DIV + 1);
    localparam int MIN_DIV        = 2;

    typedef logic [CLKDIV_DW-1:0] div_t;

    // A ratio below 2 cannot produce a clock with both a high and a low phase.
    function automatic logic legal_div(input logic [31:0] div, input logic [31:0] maxdiv);
        return (div >= 32'(MIN_DIV)) && (div <= maxdiv);
    endfunction

endpackage

// File: rtl/ehgu_clkdiv_prog_ch.sv
// One divider channel: modulo counter, shadow ratio, park logic and 50% duty flops.
// Build option: EHGU_CLKDIV_TICK_EN adds the registered period-start tick output.
module ehgu_clkdiv_prog_ch
    import ehgu_basic_pkg::*;
#(
    parameter int MAX_DIV = 256,
    parameter int DEF_DIV = 2,
    localparam int DW = $clog2(MAX_DIV + 1)
) (
    input  logic          clkin,
    input  logic          rstn,
    input  logic          en,
    input  logic          wr,
    input  logic [DW-1:0] wr_div,
    output logic          busy,
`ifdef EHGU_CLKDIV_TICK_EN
    output logic          tick,
`endif
    output logic          clkout
);

    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_next;
    logic [DW-1:0] div;
    logic [DW-1:0] shadow;
    logic [DW-1:0] half;
    logic          run;
    logic          run_next;
    logic          boundary;
    logic          p;
    logic          p_next;
    logic          n;

    // A parked channel sits on a boundary every cycle; en is only sampled at boundaries.
    assign boundary = ~run | (cnt == div - DW'(1));
    assign run_next = boundary ? en : 1'b1;
    assign cnt_next = run ? DW'(increment_modulo_unsigned(32'(cnt), 32'(div))) : '0;
    assign half     = DW'((32'(div) + 32'd1) >> 1);
    assign p_next   = run_next & (cnt_next < half);

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            run    <= 1'b0;
            p      <= 1'b0;
            div    <= DW'(DEF_DIV);
            shadow <= DW'(DEF_DIV);
            busy   <= 1'b0;
        end else begin
            cnt <= cnt_next;
            run <= run_next;
            p   <= p_next;
            // wr is only possible while not busy, so it never collides with an apply.
            if (wr) begin
                shadow <= wr_div;
                busy   <= 1'b1;
            end else if (busy && boundary) begin
                div  <= shadow;
                busy <= 1'b0;
            end
        end
    end

    always_ff @(negedge clkin or negedge rstn) begin
        if (!rstn) begin
            n <= 1'b0;
        end else begin
            n <= p;
        end
    end

    // Odd ratios lose half a clkin cycle of high time by ANDing with the negedge copy.
    assign clkout = div[0] ? (p & n) : p;

`ifdef EHGU_CLKDIV_TICK_EN
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            tick <= 1'b0;
        end else begin
            tick <= boundary & run_next;
        end
    end
`endif

endmodule

// File: rtl/ehgu_clkdiv_prog.sv
// Multi-channel run-time programmable clock divider with glitch-free ratio changes.
// Build option: define EHGU_CLKDIV_TICK_EN to add the per-channel tick output.
module ehgu_clkdiv_prog
    import ehgu_clkdiv_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MAX_DIV = CLKDIV_MAX_DIV,
    parameter int DEF_DIV = MIN_DIV,
    localparam int DW = $clog2(MAX_DIV + 1),
    localparam int CW = $clog2(NCH) | 1
) (
    input  logic           clkin,
    input  logic           rstn,
    input  logic [NCH-1:0] en,
    input  logic           cfg_valid,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    output logic           cfg_ready,
    output logic           cfg_err,
    output logic [NCH-1:0] busy,
`ifdef EHGU_CLKDIV_TICK_EN
    output logic [NCH-1:0] tick,
`endif
    output logic [NCH-1:0] clkout
);

    logic           sel_busy;
    logic           ch_ok;
    logic           div_ok;
    logic           accept;
    logic [NCH-1:0] wr;

    // Out-of-range channels read as not busy so the write is taken and flagged as an error.
    always_comb begin
        sel_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (32'(cfg_ch) == 32'(i)) begin
                sel_busy = busy[i];
            end
        end
    end

    assign cfg_ready = ~sel_busy;
    assign ch_ok     = 32'(cfg_ch) < 32'(NCH);
    assign div_ok    = legal_div(32'(cfg_div), 32'(MAX_DIV));
    assign accept    = cfg_valid & cfg_ready;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & ~(ch_ok & div_ok);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign wr[g] = accept & ch_ok & div_ok & (32'(cfg_ch) == 32'(g));

        ehgu_clkdiv_prog_ch #(
            .MAX_DIV (MAX_DIV),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clkin   (clkin),
            .rstn    (rstn),
            .en      (en[g]),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .busy    (busy[g]),
`ifdef EHGU_CLKDIV_TICK_EN
            .tick    (tick[g]),
`endif
            .clkout  (clkout[g])
        );
    end

endmodule

// File: tb/tb_ehgu_clkdiv_prog.sv
// Directed bench for ehgu_clkdiv_prog: ratios, duty, pending ratio changes, errors and parking.
module tb_ehgu_clkdiv_prog;

    localparam int NCH     = 4;
    localparam int MAX_DIV = 256;
    localparam int DW      = $clog2(MAX_DIV + 1);
    localparam int CW      = $clog2(NCH) | 1;

    logic           clkin = 1'b0;
    logic           rstn;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic [CW-1:0]  cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_ready;
    logic           cfg_err;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] clkout;
`ifdef EHGU_CLKDIV_TICK_EN
    logic [NCH-1:0] tick;
`endif

    int checkCount = 0;
    int errorCount = 0;

    ehgu_clkdiv_prog #(
        .NCH     (NCH),
        .MAX_DIV (MAX_DIV),
        .DEF_DIV (2)
    ) dut (
        .clkin     (clkin),
        .rstn      (rstn),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .busy      (busy),
`ifdef EHGU_CLKDIV_TICK_EN
        .tick      (tick),
`endif
        .clkout    (clkout)
    );

    always #5 clkin = ~clkin;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clkin);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) nextCycle();
    endtask

    // One-cycle write request, released one time unit after the accepting edge.
    task automatic applyStimulus(input int ch, input int div);
        cfg_ch    = CW'(ch);
        cfg_div   = DW'(div);
        cfg_valid = 1'b1;
        nextCycle();
        cfg_valid = 1'b0;
    endtask

    // Samples every half clkin cycle; returns high time and period in half cycles.
    task automatic measureClk(input int ch, output int highH, output int periodH);
        logic prev;
        logic cur;
        logic found;
        logic inHigh;
        highH   = 0;
        periodH = 0;
        found   = 1'b0;
        nextCycle();
        prev = clkout[ch];
        for (int i = 0; i < 1000; i++) begin
            #5;
            cur = clkout[ch];
            if (!prev && cur) begin
                found = 1'b1;
                break;
            end
            prev = cur;
        end
        if (!found) begin
            checkOutput("measure rise timeout", 32'd0, 32'd1);
            return;
        end
        highH   = 1;
        periodH = 1;
        inHigh  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            #5;
            cur = clkout[ch];
            if (cur && !inHigh) break;
            periodH++;
            if (cur) highH++;
            else inHigh = 1'b0;
        end
    endtask

    // Returns in the cycle right after clkout[ch] rose at a posedge (counter at 0).
    task automatic syncRise(input int ch);
        logic prev;
        logic found;
        found = 1'b0;
        prev  = clkout[ch];
        for (int i = 0; i < 100; i++) begin
            nextCycle();
            if (!prev && clkout[ch]) begin
                found = 1'b1;
                break;
            end
            prev = clkout[ch];
        end
        if (!found) checkOutput("sync rise timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int highH;
        int periodH;
        logic [10:0] clkSeq;
        logic [10:0] busySeq;
        logic [16:0] parkSeq;
        logic        released;
        int          badCh[4];
        int          badDiv[4];

        rstn      = 1'b0;
        en        = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;

        #22;
        checkOutput("reset clkout", 32'(clkout), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);

        nextCycle();
        rstn = 1'b1;
        en   = '1;
        waitCycles(2);

        $display("[TB] default ratio after reset");
        measureClk(0, highH, periodH);
        checkOutput("ch0 D2 high", 32'(highH), 32'd2);
        checkOutput("ch0 D2 period", 32'(periodH), 32'd4);
        measureClk(3, highH, periodH);
        checkOutput("ch3 D2 period", 32'(periodH), 32'd4);

        $display("[TB] reset while a ratio is pending");
        applyStimulus(1, 200);
        waitCycles(3);
        checkOutput("ch1 applied D200", 32'(busy[1]), 32'd0);
        applyStimulus(1, 4);
        checkOutput("ch1 pending busy", 32'(busy[1]), 32'd1);
        waitCycles(10);
        rstn = 1'b0;
        #1;
        checkOutput("midrun reset clkout", 32'(clkout), 32'd0);
        checkOutput("midrun reset busy", 32'(busy), 32'd0);
        waitCycles(2);
        rstn = 1'b1;
        measureClk(1, highH, periodH);
        checkOutput("ch1 post-reset high", 32'(highH), 32'd2);
        checkOutput("ch1 post-reset period", 32'(periodH), 32'd4);

        $display("[TB] even and odd ratios");
        applyStimulus(0, 4);
        waitCycles(4);
        measureClk(0, highH, periodH);
        checkOutput("ch0 D4 high", 32'(highH), 32'd4);
        checkOutput("ch0 D4 period", 32'(periodH), 32'd8);
        applyStimulus(1, 5);
        waitCycles(6);
        measureClk(1, highH, periodH);
        checkOutput("ch1 D5 high", 32'(highH), 32'd5);
        checkOutput("ch1 D5 period", 32'(periodH), 32'd10);

        $display("[TB] ratio change mid-period");
        syncRise(0);
        for (int k = 0; k < 11; k++) begin
            clkSeq[k]  = clkout[0];
            busySeq[k] = busy[0];
            if (k == 1) begin
                cfg_ch    = CW'(0);
                cfg_div   = DW'(6);
                cfg_valid = 1'b1;
            end
            if (k == 2) cfg_valid = 1'b0;
            nextCycle();
        end
        checkOutput("ch0 4->6 clkout seq", 32'(clkSeq), 32'(11'b10001110011));
        checkOutput("ch0 4->6 busy seq", 32'(busySeq), 32'(11'b00000001100));

        $display("[TB] illegal writes");
        badCh  = '{0, 0, 0, NCH};
        badDiv = '{1, 0, MAX_DIV + 1, 5};
        for (int t = 0; t < 4; t++) begin
            cfg_ch    = CW'(badCh[t]);
            cfg_div   = DW'(badDiv[t]);
            cfg_valid = 1'b1;
            #1;
            checkOutput($sformatf("illegal%0d ready", t), 32'(cfg_ready), 32'd1);
            nextCycle();
            cfg_valid = 1'b0;
            checkOutput($sformatf("illegal%0d err", t), 32'(cfg_err), 32'd1);
            checkOutput($sformatf("illegal%0d busy", t), 32'(busy), 32'd0);
            nextCycle();
            checkOutput($sformatf("illegal%0d err drop", t), 32'(cfg_err), 32'd0);
        end
        measureClk(0, highH, periodH);
        checkOutput("ch0 D6 unchanged high", 32'(highH), 32'd6);
        checkOutput("ch0 D6 unchanged period", 32'(periodH), 32'd12);

        $display("[TB] write while busy");
        applyStimulus(2, 200);
        waitCycles(3);
        applyStimulus(2, 8);
        checkOutput("ch2 busy after write", 32'(busy[2]), 32'd1);
        cfg_ch    = CW'(2);
        cfg_div   = DW'(3);
        cfg_valid = 1'b1;
        #1;
        checkOutput("ch2 ready while busy", 32'(cfg_ready), 32'd0);
        nextCycle();
        cfg_valid = 1'b0;
        checkOutput("ch2 rejected no err", 32'(cfg_err), 32'd0);
        released = 1'b0;
        for (int i = 0; i < 300; i++) begin
            nextCycle();
            if (!busy[2]) begin
                released = 1'b1;
                break;
            end
        end
        checkOutput("ch2 pending applied", 32'(released), 32'd1);
        measureClk(2, highH, periodH);
        checkOutput("ch2 D8 high", 32'(highH), 32'd8);
        checkOutput("ch2 D8 period", 32'(periodH), 32'd16);

        $display("[TB] enable drop and restart");
        syncRise(0);
        for (int k = 0; k < 17; k++) begin
            parkSeq[k] = clkout[0];
            if (k == 2) en[0] = 1'b0;
            if (k == 9) en[0] = 1'b1;
            nextCycle();
        end
        checkOutput("ch0 park/restart seq", 32'(parkSeq), 32'(17'b10001110000000111));

        en[3] = 1'b0;
        waitCycles(4);
        applyStimulus(3, 10);
        checkOutput("ch3 parked busy", 32'(busy[3]), 32'd1);
        nextCycle();
        checkOutput("ch3 parked applied", 32'(busy[3]), 32'd0);
        checkOutput("ch3 parked clkout", 32'(clkout[3]), 32'd0);

`ifdef EHGU_CLKDIV_TICK_EN
        begin
            logic [8:0] tickSeq;
            int         ones;
            en[3] = 1'b1;
            applyStimulus(3, 3);
            waitCycles(12);
            ones = 0;
            for (int k = 0; k < 9; k++) begin
                tickSeq[k] = tick[3];
                if (tick[3]) ones++;
                nextCycle();
            end
            checkOutput("ch3 tick count", 32'(ones), 32'd3);
            checkOutput("ch3 tick spacing", 32'(tickSeq & (tickSeq >> 1)), 32'd0);
        end
`endif

        $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
